// File: rtl/filtro_azar_pkg.sv
// rtl/filtro_azar_pkg.sv - shared defaults, counter-state type and width helper for the hazard filter
package filtro_azar_pkg;

    localparam int FA_W    = 4;
    localparam int FA_N    = 8;
    localparam int FA_SYNC = 2;

    // IDLE: no change pending (cnt = 0); COUNT: a change is being qualified
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } cnt_state_e;

    // Bits needed to hold 0..value-1; never less than one bit so N=2 still works
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/filtro_canal.sv
// rtl/filtro_canal.sv - one filter channel: synchroniser, stability counter, output and event pulses
module filtro_canal
    import filtro_azar_pkg::*;
#(
    parameter int N    = FA_N,
    parameter int SYNC = FA_SYNC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a,
    output logic f,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int            CW       = clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [SYNC-1:0] sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            f_q, f_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            glitch_q, glitch_d;
    logic            s;
    cnt_state_e      state;

    assign s     = sync_q[SYNC-1];
    assign state = (cnt_q == '0) ? ST_IDLE : ST_COUNT;

    // Next-state: shift the synchroniser and qualify any difference between s and f
    always_comb begin
        sync_d   = {sync_q[SYNC-2:0], a};
        cnt_d    = cnt_q;
        f_d      = f_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        if (s != f_q) begin
            if (cnt_q == CNT_LAST) begin
                // Held long enough: commit and announce the edge
                f_d    = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state == ST_COUNT) begin
            // Input went back before the window closed: drop the pending change
            cnt_d    = '0;
            glitch_d = 1'b1;
        end
    end

    // State registers; reset clears everything so the channel restarts in IDLE with f=0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            f_q      <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign f      = f_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign glitch = glitch_q;

endmodule

// File: rtl/filtro_azar.sv
// rtl/filtro_azar.sv - multi-channel hazard/glitch filter built from independent channels
module filtro_azar
    import filtro_azar_pkg::*;
#(
    parameter int W    = FA_W,
    parameter int N    = FA_N,
    parameter int SYNC = FA_SYNC
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] a,
    output logic [W-1:0] f,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic [W-1:0] glitch
);

    // One self-contained channel per input bit; channels share only clock and reset
    for (genvar i = 0; i < W; i++) begin : g_canal
        filtro_canal #(
            .N    (N),
            .SYNC (SYNC)
        ) u_canal (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (a[i]),
            .f       (f[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .glitch  (glitch[i])
        );
    end

endmodule
